// File: rtl/iob_serializer.sv
// iob_serializer: parallel-to-serial output serializer for a tristate pad.
// Accepts WIDTH-bit words over a valid/ready handshake and shifts them out
// one bit per clock on O with T=0. Between words the pad is released to
// IDLE_O / IDLE_T. Back-to-back words stream with no gap bit.
//
// Handshake: a word transfers on a rising CLK edge where D_VALID and D_READY
// are both high. D_READY is combinational, high in IDLE or on the final bit
// of a word, and low while RSTN is low. D_VALID may drop or change without a
// transfer; D is only looked at on the transferring edge.
module iob_serializer #(
  parameter int   WIDTH     = 4,
  parameter bit   LSB_FIRST = 1'b1,
  parameter logic IDLE_O    = 1'b1,
  parameter logic IDLE_T    = 1'b1
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [WIDTH-1:0] D,
  input  logic             D_VALID,
  output logic             D_READY,
  output logic             O,
  output logic             T,
  output logic             FRAME,
  output logic             BUSY
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             o_q, o_d;
  logic             t_q, t_d;
  logic             frame_q, frame_d;
  logic             last_bit;
  logic             accept;

  // The shift register holds the bits not yet presented; the presented bit
  // lives in o_q, so loading already consumes the first bit of the word.
  assign last_bit = (cnt_q == LAST);
  assign D_READY  = RSTN & ((state_q == IDLE) | last_bit);
  assign accept   = D_VALID & D_READY;

  // Next-state and next-output decode; load beats shift, shift beats release.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    o_d     = o_q;
    t_d     = t_q;
    frame_d = 1'b0;
    if (accept) begin
      state_d = SHIFT;
      cnt_d   = '0;
      sr_d    = LSB_FIRST ? (D >> 1) : (D << 1);
      o_d     = LSB_FIRST ? D[0] : D[WIDTH-1];
      t_d     = 1'b0;
      frame_d = 1'b1;
    end else if ((state_q == SHIFT) && !last_bit) begin
      cnt_d   = cnt_q + 1'b1;
      sr_d    = LSB_FIRST ? (sr_q >> 1) : (sr_q << 1);
      o_d     = LSB_FIRST ? sr_q[0] : sr_q[WIDTH-1];
      t_d     = 1'b0;
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
      o_d     = IDLE_O;
      t_d     = IDLE_T;
    end
  end

  // State and registered pad outputs; reset releases the pad at once.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      o_q     <= IDLE_O;
      t_q     <= IDLE_T;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      o_q     <= o_d;
      t_q     <= t_d;
      frame_q <= frame_d;
    end
  end

  assign O     = o_q;
  assign T     = t_q;
  assign FRAME = frame_q;
  assign BUSY  = ~t_q;

endmodule

// File: tb/tb_iob_serializer.sv
// tb_iob_serializer: four serializer lanes (W4 LSB-first, W4 MSB-first,
// W2 with IDLE_O=0, W16) against a bit-queue reference model, plus directed
// literal checks of the single-word, streaming, hold-off, reset and
// width-corner cases.
module tb_iob_serializer;

  // ---------------- clock / reset ----------------
  logic CLK  = 1'b0;
  logic RSTN = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- DUT lanes ----------------
  logic [3:0]  dv;
  logic [15:0] dw [4];
  logic [3:0]  rdy_v, o_v, t_v, fr_v, busy_v;
  logic [3:0]  d0, d1;
  logic [1:0]  d2;
  logic [15:0] d3;

  assign d0 = dw[0][3:0];
  assign d1 = dw[1][3:0];
  assign d2 = dw[2][1:0];
  assign d3 = dw[3];

  int   lw     [4] = '{4, 4, 2, 16};
  bit   lsb    [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic idle_o [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  iob_serializer #(.WIDTH(4), .LSB_FIRST(1'b1), .IDLE_O(1'b1), .IDLE_T(1'b1)) u_l0 (
    .CLK(CLK), .RSTN(RSTN), .D(d0), .D_VALID(dv[0]), .D_READY(rdy_v[0]),
    .O(o_v[0]), .T(t_v[0]), .FRAME(fr_v[0]), .BUSY(busy_v[0]));
  iob_serializer #(.WIDTH(4), .LSB_FIRST(1'b0), .IDLE_O(1'b1), .IDLE_T(1'b1)) u_l1 (
    .CLK(CLK), .RSTN(RSTN), .D(d1), .D_VALID(dv[1]), .D_READY(rdy_v[1]),
    .O(o_v[1]), .T(t_v[1]), .FRAME(fr_v[1]), .BUSY(busy_v[1]));
  iob_serializer #(.WIDTH(2), .LSB_FIRST(1'b1), .IDLE_O(1'b0), .IDLE_T(1'b1)) u_l2 (
    .CLK(CLK), .RSTN(RSTN), .D(d2), .D_VALID(dv[2]), .D_READY(rdy_v[2]),
    .O(o_v[2]), .T(t_v[2]), .FRAME(fr_v[2]), .BUSY(busy_v[2]));
  iob_serializer #(.WIDTH(16), .LSB_FIRST(1'b1), .IDLE_O(1'b1), .IDLE_T(1'b1)) u_l3 (
    .CLK(CLK), .RSTN(RSTN), .D(d3), .D_VALID(dv[3]), .D_READY(rdy_v[3]),
    .O(o_v[3]), .T(t_v[3]), .FRAME(fr_v[3]), .BUSY(busy_v[3]));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: per lane, the queue of bits still to appear on the pad.
  // Front of the queue is the bit currently driven. Ready means at most the
  // current bit remains; an accept appends the whole word in shift order.
  logic [0:0] exp_q [4][$];
  logic       exp_fr [4];
  logic       m_acc;

  initial begin
    for (int l = 0; l < 4; l++) exp_fr[l] = 1'b0;
    forever begin
      @(posedge CLK or negedge RSTN);
      for (int l = 0; l < 4; l++) begin
        if (!RSTN) begin
          exp_q[l].delete();
          exp_fr[l] = 1'b0;
        end else begin
          m_acc = dv[l] && (exp_q[l].size() <= 1);
          if (exp_q[l].size() > 0) void'(exp_q[l].pop_front());
          if (m_acc)
            for (int i = 0; i < lw[l]; i++)
              exp_q[l].push_back(lsb[l] ? dw[l][i] : dw[l][lw[l]-1-i]);
          exp_fr[l] = m_acc;
        end
      end
    end
  end

  // Compare every lane against the model on each falling edge.
  logic e_empty;
  logic [4:0] e_vec, g_vec;
  initial begin
    forever begin
      @(negedge CLK);
      if (chk_en) begin
        for (int l = 0; l < 4; l++) begin
          e_empty = (exp_q[l].size() == 0);
          e_vec = {e_empty ? idle_o[l] : exp_q[l][0][0], e_empty, exp_fr[l], ~e_empty,
                   RSTN && (exp_q[l].size() <= 1)};
          g_vec = {o_v[l], t_v[l], fr_v[l], busy_v[l], rdy_v[l]};
          check($sformatf("lane%0d_o_t_frame_busy_ready", l), 32'(g_vec), 32'(e_vec));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    dv = '0;
    repeat (n) tick();
  endtask

  // ---------------- directed + random stimulus ----------------
  logic [3:0]  s0, s1, f0, t0, r4;
  logic [7:0]  s8, f8, r8, t8;
  logic [1:0]  s2, r2;
  logic [15:0] s16, r16, f16;
  logic        t2;

  initial begin
    dv = '0;
    for (int l = 0; l < 4; l++) dw[l] = '0;
    chk_en = 1'b1;
    repeat (2) @(negedge CLK);
    check("reset_lane0", 32'({o_v[0], t_v[0], fr_v[0], busy_v[0], rdy_v[0]}), 32'h18);
    check("reset_lane2", 32'({o_v[2], t_v[2], fr_v[2], busy_v[2], rdy_v[2]}), 32'h08);
    @(posedge CLK);
    #1 RSTN = 1'b1;
    idle_cycles(2);

    // Single word 1101, LSB-first on lane 0 and MSB-first on lane 1.
    dw[0] = 16'hD; dw[1] = 16'hD; dv[1:0] = 2'b11;
    tick();
    dv = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      s0[c] = o_v[0]; s1[c] = o_v[1]; f0[c] = fr_v[0]; t0[c] = t_v[0];
    end
    @(negedge CLK);
    check("single_lsb_bits", 32'(s0), 32'hD);
    check("single_msb_bits", 32'(s1), 32'hB);
    check("single_frame", 32'(f0), 32'h1);
    check("single_t", 32'(t0), 32'h0);
    check("single_release_l0", 32'({o_v[0], t_v[0], busy_v[0]}), 32'h6);
    check("single_release_l1", 32'({o_v[1], t_v[1], busy_v[1]}), 32'h6);
    idle_cycles(3);

    // Streaming A then 5 with D_VALID held high.
    dw[0] = 16'hA; dv[0] = 1'b1;
    tick();
    dw[0] = 16'h5;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      s8[c] = o_v[0]; f8[c] = fr_v[0]; r8[c] = rdy_v[0]; t8[c] = t_v[0];
      tick();
      if (c == 3) dv[0] = 1'b0;
    end
    check("stream_bits", 32'(s8), 32'h5A);
    check("stream_frame", 32'(f8), 32'h11);
    check("stream_ready", 32'(r8), 32'h88);
    check("stream_t", 32'(t8), 32'h00);
    idle_cycles(3);

    // Hold-off: F offered during bit 1 of word 6.
    dw[0] = 16'h6; dv[0] = 1'b1;
    tick();
    dv[0] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      s8[c] = o_v[0]; f8[c] = fr_v[0]; r8[c] = rdy_v[0];
      tick();
      if (c == 0) begin dw[0] = 16'hF; dv[0] = 1'b1; end
      if (c == 3) dv[0] = 1'b0;
    end
    check("holdoff_bits", 32'(s8), 32'hF6);
    check("holdoff_frame", 32'(f8), 32'h11);
    check("holdoff_ready", 32'(r8), 32'h88);
    idle_cycles(3);

    // Reset during bit 2, then word 3 from a clean start.
    dw[0] = 16'h9; dv[0] = 1'b1;
    tick();
    dv[0] = 1'b0;
    repeat (3) @(negedge CLK);
    #1 RSTN = 1'b0;
    #1;
    check("midreset_pad", 32'({o_v[0], t_v[0], busy_v[0], rdy_v[0]}), 32'hC);
    repeat (2) @(negedge CLK);
    #2;
    RSTN = 1'b1; dw[0] = 16'h3; dv[0] = 1'b1;
    tick();
    dv[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      s0[c] = o_v[0]; f0[c] = fr_v[0]; r4[c] = rdy_v[0];
    end
    check("postreset_bits", 32'(s0), 32'h3);
    check("postreset_frame", 32'(f0), 32'h1);
    check("postreset_ready", 32'(r4), 32'h8);
    idle_cycles(3);

    // Width corners: 2-bit and 16-bit lanes.
    dw[2] = 16'h2; dw[3] = 16'hA5C3; dv[3:2] = 2'b11;
    tick();
    dv = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge CLK);
      s16[c] = o_v[3]; r16[c] = rdy_v[3]; f16[c] = fr_v[3];
      if (c < 2) begin s2[c] = o_v[2]; r2[c] = rdy_v[2]; end
      if (c == 2) t2 = t_v[2];
    end
    @(negedge CLK);
    check("w2_bits", 32'(s2), 32'h2);
    check("w2_ready", 32'(r2), 32'h2);
    check("w2_release_t", 32'(t2), 32'h1);
    check("w16_bits", 32'(s16), 32'hA5C3);
    check("w16_ready", 32'(r16), 32'h8000);
    check("w16_frame", 32'(f16), 32'h0001);
    check("w16_release", 32'({o_v[3], t_v[3], busy_v[3]}), 32'h6);
    idle_cycles(2);

    // Random traffic with occasional asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      tick();
      for (int l = 0; l < 4; l++) begin
        dv[l] = ($urandom_range(0, 3) != 0);
        dw[l] = 16'($urandom);
      end
      if (!RSTN) RSTN = 1'b1;
      else if ($urandom_range(0, 299) == 0) RSTN = 1'b0;
    end
    RSTN = 1'b1;
    idle_cycles(24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iob_serializer.md
# iob_serializer

Single-clock parallel-to-serial output serializer that feeds the pad-side output buffer pair (`O` → buffer `I`, `T` → buffer `T`) of an xc7 tristate output pad. It accepts `WIDTH`-bit words over a valid/ready handshake and shifts them out one bit per clock, driving the pad only while a word is on the wire. Between words it releases the pad to a programmable idle level and tristate state. Back-to-back words stream with no gap bit.

## Interface
Parameters:
- `WIDTH`, 4, bits per word; legal range 2..16.
- `LSB_FIRST`, 1, 1: bit 0 is shifted first; 0: bit `WIDTH-1` is shifted first.
- `IDLE_O`, 1'b1, value on `O` while idle and in reset.
- `IDLE_T`, 1'b1, value on `T` while idle and in reset (1 = pad released / high-Z).

Ports:
- `CLK`  input  1  sole clock; all state updates on the rising edge.
- `RSTN`  input  1  asynchronous, active-low reset.
- `D`  input  `WIDTH`  parallel word; sampled on the accepting edge.
- `D_VALID`  input  1  `D` holds a word to send.
- `D_READY`  output  1  serializer accepts `D` at this edge if `D_VALID` is also high.
- `O`  output  1  serial data to the output buffer data input; registered.
- `T`  output  1  tristate control to the output buffer; 0 = drive; registered.
- `FRAME`  output  1  high during the first bit of each word; registered.
- `BUSY`  output  1  high while a word is being shifted (`T`==0).

## Operation
- States: IDLE, SHIFT. Bit counter `cnt` is `clog2(WIDTH)` bits wide; shift register `sr` is `WIDTH` bits wide.
- Accept = `D_VALID & D_READY` at a rising edge.
- `D_READY` is combinational: 1 in IDLE, or in SHIFT when `cnt == WIDTH-1`; forced 0 while `RSTN` is low.
- IDLE + accept:
  - load `sr` from `D`; `cnt` ← 0; go to SHIFT.
  - `O` ← first bit; `T` ← 0; `FRAME` ← 1.
- IDLE with no accept: `O` = `IDLE_O`, `T` = `IDLE_T`, `FRAME` = 0.
- SHIFT with `cnt < WIDTH-1`: present the next bit; `cnt` += 1; `FRAME` ← 0; `T` stays 0.
- SHIFT with `cnt == WIDTH-1` and accept: reload from `D`, `cnt` ← 0, `FRAME` ← 1; stay in SHIFT. No idle bit is inserted.
- SHIFT with `cnt == WIDTH-1` and no accept: return to IDLE; `O` ← `IDLE_O`, `T` ← `IDLE_T`.
- Bit order: the `LSB_FIRST` setting applies to every word.
- `D` is ignored outside accepting edges. A change on `D_VALID` or `D` mid-word has no effect.
- `BUSY` = ~`T`, taken from the registered value.

## Timing
- Reset values (asynchronous, held while `RSTN` = 0): state IDLE, `cnt` 0, `sr` 0, `O` = `IDLE_O`, `T` = `IDLE_T`, `FRAME` 0, `BUSY` 0, `D_READY` 0.
- Latency: if a word is accepted at edge k, its first bit is valid on `O` from edge k until edge k+1. Bit i is valid from edge k+i until edge k+i+1.
- Released pad: with no follow-on word, `T` returns to `IDLE_T` at edge k+`WIDTH`.
- Throughput: one word per `WIDTH` cycles when `D_VALID` is held high.
- Reset mid-word: the word in flight is abandoned, `T` releases immediately, and no partial bits resume after reset. The first accept is possible at the first rising edge with `RSTN` high.
- `D_VALID` high during the non-final bits of SHIFT: the word is held off. It is accepted on the final-bit edge with no stall cycle.

## Test plan
- Single word, `WIDTH`=4, `LSB_FIRST`=1, `D`=4'b1101 accepted at edge 0:
  - `O` = 1,0,1,1 on cycles 0..3 with `T`=0 and `FRAME`=1 only on cycle 0.
  - From edge 4: `O`=1, `T`=1, `BUSY`=0.
- MSB-first, `D`=4'b1101: `O` = 1,1,0,1.
- Streaming, `D_VALID` held high with words 4'hA then 4'h5:
  - 8 contiguous driven bits 0,1,0,1,1,0,1,0; `T` stays 0 throughout.
  - `FRAME` high on cycles 0 and 4; `D_READY` high only on cycles 3 and 7.
- Hold-off: assert `D_VALID` with 4'hF during cycle 1 of a word. `D_READY`=0 until cycle 3; the word is accepted at the cycle 3 edge and starts at cycle 4.
- Reset mid-word: drop `RSTN` during bit 2.
  - `O`/`T` go to `IDLE_O`/`IDLE_T` immediately and `D_READY` is 0.
  - After release, a new word 4'h3 serializes cleanly from its first bit.
- `WIDTH`=2 and `WIDTH`=16 corner:
  - correct bit count and counter wrap.
  - `D_READY` asserted exactly on the last bit.
